// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the multi-channel bus synchroniser.
package data_sync_pkg;

  localparam int unsigned EN_LEVEL  = 0;
  localparam int unsigned EN_TOGGLE = 1;

  // Low bit of channel ch inside a packed NUM_CH*width bus.
  function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/data_sync_ch.sv
// One channel: qualifier synchroniser, event detect, bus capture,
// valid/ready hold register, toggle ack and sticky overrun.
module data_sync_ch
  import data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned EN_MODE    = EN_LEVEL,
  parameter int unsigned OVERWRITE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_enable,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 out_ready,
  input  logic                 clear_ovr,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 out_valid,
  output logic                 ack_toggle,
  output logic                 overrun
);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("data_sync_ch: NUM_STAGES must be at least 2");
  end
  if ((EN_MODE != EN_LEVEL) && (EN_MODE != EN_TOGGLE)) begin : g_bad_mode
    $error("data_sync_ch: EN_MODE must be 0 or 1");
  end

  logic [NUM_STAGES-1:0] sync_q, sync_d;
  logic                  edge_q, edge_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  pulse_q, pulse_d;
  logic                  valid_q, valid_d;
  logic                  ack_q, ack_d;
  logic                  ovr_q, ovr_d;

  logic qual_c, evt_c, ovr_evt_c, capture_c, xfer_c;

  always_comb begin
    sync_d    = {sync_q[NUM_STAGES-2:0], bus_enable};
    qual_c    = sync_q[NUM_STAGES-1];
    edge_d    = qual_c;
    evt_c     = (EN_MODE == EN_TOGGLE) ? (qual_c ^ edge_q) : (qual_c & ~edge_q);
    xfer_c    = valid_q & out_ready;
    ovr_evt_c = evt_c & valid_q & ~out_ready;
    // On overrun the held word is only replaced when overwriting is enabled.
    capture_c = evt_c & (~ovr_evt_c | (OVERWRITE != 0));

    data_d  = data_q;
    pulse_d = capture_c;
    ack_d   = ack_q ^ capture_c;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (capture_c) begin
      data_d  = unsync_bus;
      valid_d = 1'b1;
    end else if (xfer_c) begin
      valid_d = 1'b0;
    end

    if (ovr_evt_c) begin
      ovr_d = 1'b1;
    end else if (clear_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      data_q  <= '0;
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sync_bus     = data_q;
  assign enable_pulse = pulse_q;
  assign out_valid    = valid_q;
  assign ack_toggle   = ack_q;
  assign overrun      = ovr_q;

endmodule

// File: rtl/data_sync_mc.sv
// NUM_CH independent bus synchroniser channels in the destination clock domain.
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned EN_MODE    = EN_LEVEL,
  parameter int unsigned OVERWRITE  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             bus_enable,
  input  logic [NUM_CH*BUS_WIDTH-1:0]   unsync_bus,
  output logic [NUM_CH*BUS_WIDTH-1:0]   sync_bus,
  output logic [NUM_CH-1:0]             enable_pulse,
  output logic [NUM_CH-1:0]             out_valid,
  input  logic [NUM_CH-1:0]             out_ready,
  output logic [NUM_CH-1:0]             ack_toggle,
  output logic [NUM_CH-1:0]             overrun,
  input  logic [NUM_CH-1:0]             clear_ovr
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned lo = slice_lo(32'(c), BUS_WIDTH);

    data_sync_ch #(
      .NUM_STAGES (NUM_STAGES),
      .BUS_WIDTH  (BUS_WIDTH),
      .EN_MODE    (EN_MODE),
      .OVERWRITE  (OVERWRITE)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .bus_enable   (bus_enable[c]),
      .unsync_bus   (unsync_bus[lo +: BUS_WIDTH]),
      .out_ready    (out_ready[c]),
      .clear_ovr    (clear_ovr[c]),
      .sync_bus     (sync_bus[lo +: BUS_WIDTH]),
      .enable_pulse (enable_pulse[c]),
      .out_valid    (out_valid[c]),
      .ack_toggle   (ack_toggle[c]),
      .overrun      (overrun[c])
    );
  end

endmodule
